ps2_keys: RTL and testbench

PS2_KEYS -- requirements
Module: ps2_keys

---
 rtl/ps2_keys.sv | 152 +++++++++++++++
 tb/tb_ps2_keys.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keys.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit odd-parity frames and tracks held left/right keys.
// Optional stalled-frame timeout is enabled with macro PS2_TIMEOUT_EN.
module ps2_keys #(
  parameter logic [7:0]  LEFT_CODE      = 8'h6B,
  parameter logic [7:0]  RIGHT_CODE     = 8'h74,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [1:0] keys,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     state, state_next;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift;
  logic       parity_bit;
  logic       break_pending;

  logic clk_s1, clk_s2, clk_s3;
  logic data_s1, data_s2;
  logic fall;
  logic timeout;
  logic frame_done;
  logic frame_ok;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  // Sync flops reset high so releasing reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      clk_s3  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_s3  <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  assign fall = clk_s3 & ~clk_s2;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcount;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcount <= '0;
    end else if (fall || state == IDLE) begin
      tcount <= '0;
    end else begin
      tcount <= tcount + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && !fall && (tcount == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    if (timeout) begin
      state_next   = IDLE;
      bit_cnt_next = '0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s2) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign frame_done = fall && (state == STOP);
  assign frame_ok   = data_s2 && (^{shift, parity_bit});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift      <= '0;
      parity_bit <= 1'b0;
    end else if (fall) begin
      if (state == DATA)   shift      <= {data_s2, shift[7:1]};
      if (state == PARITY) parity_bit <= data_s2;
    end
  end

  // Rejected frames touch nothing but the error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keys          <= '0;
      code          <= '0;
      code_valid    <= 1'b0;
      frame_err     <= 1'b0;
      break_pending <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= timeout;
      if (frame_done) begin
        if (frame_ok) begin
          code       <= shift;
          code_valid <= 1'b1;
          if (shift == 8'hF0) begin
            break_pending <= 1'b1;
          end else if (shift != 8'hE0) begin
            if (shift == LEFT_CODE)  keys[0] <= ~break_pending;
            if (shift == RIGHT_CODE) keys[1] <= ~break_pending;
            break_pending <= 1'b0;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keys.sv
// Directed bench for ps2_keys: table of whole frames plus hand sequences for latency, mid-frame reset and stalls.
module tb_ps2_keys;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [1:0] keys;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned v_cnt    = 0;
  int unsigned e_cnt    = 0;
  logic        cv_prev  = 1'b0;
  logic        fe_prev  = 1'b0;

  ps2_keys #(.LEFT_CODE(8'h6B), .RIGHT_CODE(8'h74), .TIMEOUT_CYCLES(5000)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keys(keys), .code(code), .code_valid(code_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse counters; any pulse must last exactly one cycle.
  always @(negedge clk) begin
    if (cv_prev) check("code_valid_width", {31'd0, code_valid}, 32'd0);
    if (fe_prev) check("frame_err_width", {31'd0, frame_err}, 32'd0);
    if (code_valid && !cv_prev) v_cnt++;
    if (frame_err && !fe_prev) e_cnt++;
    cv_prev = code_valid;
    fe_prev = frame_err;
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input bit good, input bit stop);
    logic par;
    par = good ? ~^d : ^d;
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(4);
      ps2_clk = 1'b0;
      wait_cyc(8);
      ps2_clk = 1'b1;
      wait_cyc(4);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          good;
    bit          stop;
    logic [7:0]  exp_code;
    logic [1:0]  exp_keys;
    int unsigned exp_v;
    int unsigned exp_e;
  } vec_t;

  vec_t vecs [17];

  initial begin
    int unsigned v0, e0, lat;
    bit          found;
    logic [1:0]  keys_at;
    logic [7:0]  code_at;
    logic [10:0] fr;

    vecs[0]  = '{8'h6B, 1, 1, 8'h6B, 2'b01, 1, 0};
    vecs[1]  = '{8'h74, 1, 1, 8'h74, 2'b11, 1, 0};
    vecs[2]  = '{8'hF0, 1, 1, 8'hF0, 2'b11, 1, 0};
    vecs[3]  = '{8'h6B, 1, 1, 8'h6B, 2'b10, 1, 0};
    vecs[4]  = '{8'hE0, 1, 1, 8'hE0, 2'b10, 1, 0};
    vecs[5]  = '{8'hF0, 1, 1, 8'hF0, 2'b10, 1, 0};
    vecs[6]  = '{8'h74, 1, 1, 8'h74, 2'b00, 1, 0};
    vecs[7]  = '{8'h6B, 0, 1, 8'h74, 2'b00, 0, 1};
    vecs[8]  = '{8'h6B, 1, 1, 8'h6B, 2'b01, 1, 0};
    vecs[9]  = '{8'h74, 1, 0, 8'h6B, 2'b01, 0, 1};
    vecs[10] = '{8'h74, 1, 1, 8'h74, 2'b11, 1, 0};
    vecs[11] = '{8'hF0, 1, 1, 8'hF0, 2'b11, 1, 0};
    vecs[12] = '{8'hE0, 1, 1, 8'hE0, 2'b11, 1, 0};
    vecs[13] = '{8'h74, 1, 1, 8'h74, 2'b01, 1, 0};
    vecs[14] = '{8'hF0, 1, 1, 8'hF0, 2'b01, 1, 0};
    vecs[15] = '{8'h1C, 1, 1, 8'h1C, 2'b01, 1, 0};
    vecs[16] = '{8'h74, 1, 1, 8'h74, 2'b11, 1, 0};

    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check("reset_keys", {30'd0, keys}, 32'd0);
    check("reset_code", {24'd0, code}, 32'd0);
    check("reset_code_valid", {31'd0, code_valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(5);
    check("no_false_edge", v_cnt + e_cnt, 32'd0);

    for (int unsigned i = 0; i < 17; i++) begin
      v0 = v_cnt;
      e0 = e_cnt;
      send_bits(make_frame(vecs[i].data, vecs[i].good, vecs[i].stop), 11);
      wait_cyc(6);
      check($sformatf("vec%0d_code", i), {24'd0, code}, {24'd0, vecs[i].exp_code});
      check($sformatf("vec%0d_keys", i), {30'd0, keys}, {30'd0, vecs[i].exp_keys});
      check($sformatf("vec%0d_valid_pulses", i), v_cnt - v0, vecs[i].exp_v);
      check($sformatf("vec%0d_err_pulses", i), e_cnt - e0, vecs[i].exp_e);
    end

    // Latency: code_valid and keys change together, three clk edges after ps2_clk falls on the stop bit.
    send_bits(make_frame(8'hF0, 1, 1), 11);
    fr = make_frame(8'h6B, 1, 1);
    send_bits(fr, 10);
    ps2_data = 1'b1;
    wait_cyc(4);
    ps2_clk = 1'b0;
    lat     = 0;
    found   = 1'b0;
    keys_at = 2'b00;
    code_at = 8'h00;
    for (int unsigned k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (code_valid && !found) begin
        found   = 1'b1;
        lat     = k;
        keys_at = keys;
        code_at = code;
      end
    end
    check("latency_seen", {31'd0, found}, 32'd1);
    check("latency_cycles", lat, 32'd3);
    check("latency_keys", {30'd0, keys_at}, 32'd2);
    check("latency_code", {24'd0, code_at}, 32'h6B);
    ps2_clk = 1'b1;
    wait_cyc(10);

    // Mid-frame reset with both keys held.
    send_bits(make_frame(8'h6B, 1, 1), 11);
    wait_cyc(6);
    check("pre_reset_keys", {30'd0, keys}, 32'd3);
    send_bits(make_frame(8'h74, 1, 1), 4);
    e0 = e_cnt;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_keys", {30'd0, keys}, 32'd0);
    check("async_reset_code", {24'd0, code}, 32'd0);
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    check("reset_no_err", e_cnt - e0, 32'd0);
    v0 = v_cnt;
    send_bits(make_frame(8'h74, 1, 1), 11);
    wait_cyc(6);
    check("post_reset_keys", {30'd0, keys}, 32'd2);
    check("post_reset_code", {24'd0, code}, 32'h74);
    check("post_reset_valid", v_cnt - v0, 32'd1);

    // Stalled frame: start bit plus four data bits, then silence.
    fr = make_frame(8'h6B, 1, 1);
    v0 = v_cnt;
    e0 = e_cnt;
    send_bits(fr, 5);
    ps2_data = 1'b1;
    wait_cyc(5200);
`ifdef PS2_TIMEOUT_EN
    check("timeout_err", e_cnt - e0, 32'd1);
    check("timeout_no_valid", v_cnt - v0, 32'd0);
    check("timeout_code", {24'd0, code}, 32'h74);
    v0 = v_cnt;
    send_bits(make_frame(8'h1C, 1, 1), 11);
    wait_cyc(6);
    check("after_timeout_code", {24'd0, code}, 32'h1C);
    check("after_timeout_keys", {30'd0, keys}, 32'd2);
    check("after_timeout_valid", v_cnt - v0, 32'd1);
`else
    check("stall_no_err", e_cnt - e0, 32'd0);
    check("stall_no_valid", v_cnt - v0, 32'd0);
    send_bits(fr >> 5, 6);
    wait_cyc(6);
    check("stall_resume_code", {24'd0, code}, 32'h6B);
    check("stall_resume_keys", {30'd0, keys}, 32'd3);
    check("stall_resume_valid", v_cnt - v0, 32'd1);
    check("stall_resume_err", e_cnt - e0, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
